dmx_tx: RTL and testbench



---
 rtl/dmx_tx_if.sv | 14 +
 rtl/dmx_tx.sv | 211 +++++++++++++++++++++
 tb/tb_dmx_tx.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmx_tx_if.sv
// Host-side channel-write and bank-swap bus for the DMX512 transmitter.
// The host (master) fills the shadow bank and requests swaps; swap_ack reports when one is applied.
interface dmx_tx_if #(
  parameter int ADDR_W = 9
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              swap;
  logic              swap_ack;

  modport master (output wr_en, wr_addr, wr_data, swap, input  swap_ack);
  modport slave  (input  wr_en, wr_addr, wr_data, swap, output swap_ack);
endinterface

// File: rtl/dmx_tx.sv
// DMX512 transmitter for one universe: break, MAB, start-code slot and CHANNELS data slots,
// read from a double-buffered channel memory whose banks swap only at packet boundaries.
//
// state   | meaning
// S_IDLE  | line high; leaves on enable, latching start code and applying a pending swap
// S_BREAK | line low for BREAK_CYCLES
// S_MAB   | line high for MAB_CYCLES
// S_START | start bit (low) of the current slot
// S_DATA  | 8 data bits, LSB first
// S_STOP  | 2 stop bits (high); next slot's byte is fetched here
// S_MTBS  | extra mark between slots (skipped when MTBS_CYCLES == 0)
// S_MBB   | mark before break after the last slot (skipped when MBB_CYCLES == 0)
module dmx_tx #(
  parameter int CHANNELS     = 512,
  parameter int BREAK_CYCLES = 8448,
  parameter int MAB_CYCLES   = 576,
  parameter int BIT_CYCLES   = 192,
  parameter int MTBS_CYCLES  = 0,
  parameter int MBB_CYCLES   = 0,
  parameter int ADDR_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] start_code,
  dmx_tx_if.slave    host,
  output logic       dmx_out,
  output logic       busy,
  output logic       packet_start,
  output logic       packet_done
);

  localparam int STOP_CYCLES = 2 * BIT_CYCLES;
  localparam int MAX_A  = (BREAK_CYCLES > STOP_CYCLES) ? BREAK_CYCLES : STOP_CYCLES;
  localparam int MAX_B  = (MTBS_CYCLES > MBB_CYCLES) ? MTBS_CYCLES : MBB_CYCLES;
  localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D  = (MAX_C > MAB_CYCLES) ? MAX_C : MAB_CYCLES;
  localparam int CNT_W  = $clog2(MAX_D + 1);
  localparam int SLOT_W = $clog2(CHANNELS + 1);

  localparam logic [CNT_W-1:0] BREAK_LD = CNT_W'(BREAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAB_LD   = CNT_W'(MAB_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MTBS_LD  = CNT_W'((MTBS_CYCLES > 0) ? MTBS_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] MBB_LD   = CNT_W'((MBB_CYCLES > 0) ? MBB_CYCLES - 1 : 0);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS);
  localparam logic [ADDR_W:0]   CH_LIM    = (ADDR_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_MAB, S_START, S_DATA, S_STOP, S_MTBS, S_MBB
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              bank_q, bank_d;
  logic              swap_pending_q, swap_pending_d;
  logic              dmx_out_q, dmx_out_d;
  logic              busy_q, busy_d;
  logic              packet_start_q, packet_start_d;
  logic              packet_done_q, packet_done_d;
  logic              swap_ack_q, swap_ack_d;

  logic [7:0]        mem_q [2][CHANNELS];
  logic [7:0]        rd_data_q;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_ok;
  logic              tc;

  assign tc     = (cnt_q == '0);
  assign wr_ok  = ({1'b0, host.wr_addr} < CH_LIM);
  // In STOP of slot s the byte for slot s+1 lives at channel address s.
  assign rd_idx = (slot_q < SLOT_LAST) ? slot_q[ADDR_W-1:0] : '0;

  // Writes always target the bank that is not being transmitted.
  always_ff @(posedge clock) begin
    if (host.wr_en && wr_ok) mem_q[~bank_q][host.wr_addr] <= host.wr_data;
    rd_data_q <= mem_q[bank_q][rd_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      slot_q         <= '0;
      tx_byte_q      <= '0;
      bank_q         <= 1'b0;
      swap_pending_q <= 1'b0;
      dmx_out_q      <= 1'b1;
      busy_q         <= 1'b0;
      packet_start_q <= 1'b0;
      packet_done_q  <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      slot_q         <= slot_d;
      tx_byte_q      <= tx_byte_d;
      bank_q         <= bank_d;
      swap_pending_q <= swap_pending_d;
      dmx_out_q      <= dmx_out_d;
      busy_q         <= busy_d;
      packet_start_q <= packet_start_d;
      packet_done_q  <= packet_done_d;
      swap_ack_q     <= swap_ack_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q - CNT_W'(1);
    bit_d          = bit_q;
    slot_d         = slot_q;
    tx_byte_d      = tx_byte_q;
    bank_d         = bank_q;
    swap_pending_d = swap_pending_q | host.swap;
    packet_start_d = 1'b0;
    packet_done_d  = 1'b0;
    swap_ack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (enable) begin
          state_d        = S_BREAK;
          cnt_d          = BREAK_LD;
          slot_d         = '0;
          tx_byte_d      = start_code;
          packet_start_d = 1'b1;
          if (swap_pending_q || host.swap) begin
            bank_d         = ~bank_q;
            swap_pending_d = 1'b0;
            swap_ack_d     = 1'b1;
          end
        end
      end
      S_BREAK: if (tc) begin
        state_d = S_MAB;
        cnt_d   = MAB_LD;
      end
      S_MAB: if (tc) begin
        state_d = S_START;
        cnt_d   = BIT_LD;
      end
      S_START: if (tc) begin
        state_d = S_DATA;
        cnt_d   = BIT_LD;
        bit_d   = '0;
      end
      S_DATA: if (tc) begin
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          cnt_d   = STOP_LD;
        end else begin
          bit_d = bit_q + 3'd1;
          cnt_d = BIT_LD;
        end
      end
      S_STOP: if (tc) begin
        if (slot_q == SLOT_LAST) begin
          if (MBB_CYCLES > 0) begin
            state_d = S_MBB;
            cnt_d   = MBB_LD;
          end else begin
            state_d       = S_IDLE;
            packet_done_d = 1'b1;
          end
        end else if (MTBS_CYCLES > 0) begin
          state_d = S_MTBS;
          cnt_d   = MTBS_LD;
        end else begin
          state_d   = S_START;
          cnt_d     = BIT_LD;
          tx_byte_d = rd_data_q;
          slot_d    = slot_q + SLOT_W'(1);
        end
      end
      S_MTBS: if (tc) begin
        state_d   = S_START;
        cnt_d     = BIT_LD;
        tx_byte_d = rd_data_q;
        slot_d    = slot_q + SLOT_W'(1);
      end
      S_MBB: if (tc) begin
        state_d       = S_IDLE;
        packet_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is derived from the next state so the pin is a clean flop output.
    case (state_d)
      S_BREAK, S_START: dmx_out_d = 1'b0;
      S_DATA:           dmx_out_d = tx_byte_d[bit_d];
      default:          dmx_out_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign dmx_out       = dmx_out_q;
  assign busy          = busy_q;
  assign packet_start  = packet_start_q;
  assign packet_done   = packet_done_q;
  assign host.swap_ack = swap_ack_q;

endmodule

// File: tb/tb_dmx_tx.sv
// Self-checking bench for dmx_tx: captures each packet's line waveform and compares it
// against a waveform built from the DMX framing rules and a two-bank channel model.
module tb_dmx_tx;
  localparam int CH      = 4;
  localparam int AW      = 2;
  localparam int BITC    = 4;
  localparam int BRK     = 20;
  localparam int MABC    = 6;
  localparam int MTBS    = 2;
  localparam int MBB     = 3;
  localparam int PKT_LEN = BRK + MABC + (CH + 1) * 11 * BITC + CH * MTBS + MBB;
  localparam int NPKT    = 8;
  localparam int WMAX    = 300;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] start_code;
  logic       dmx_out, busy, packet_start, packet_done;

  dmx_tx_if #(.ADDR_W(AW)) hif ();

  dmx_tx #(
    .CHANNELS(CH), .BREAK_CYCLES(BRK), .MAB_CYCLES(MABC), .BIT_CYCLES(BITC),
    .MTBS_CYCLES(MTBS), .MBB_CYCLES(MBB), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start_code(start_code),
    .host(hif.slave), .dmx_out(dmx_out), .busy(busy),
    .packet_start(packet_start), .packet_done(packet_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observation side: records what the DUT did, per packet.
  int   start_cnt = 0, done_total = 0, ack_total = 0, ack_stray = 0;
  int   cap_idx = 0, cap_n = 0;
  bit   cap_on = 1'b0;
  logic obs_wave [NPKT][WMAX];
  bit   obs_done [NPKT];
  bit   obs_ack [NPKT];
  bit   obs_busy_bad [NPKT];
  int   obs_len [NPKT];
  int   obs_start_cyc [NPKT];

  always @(negedge clock) begin
    if (packet_done === 1'b1) done_total <= done_total + 1;
    if (hif.swap_ack === 1'b1) ack_total <= ack_total + 1;
    if (hif.swap_ack === 1'b1 && packet_start !== 1'b1) ack_stray <= ack_stray + 1;
    if (reset) begin
      cap_on <= 1'b0;
    end else if (packet_start === 1'b1) begin
      if (start_cnt < NPKT) begin
        obs_wave[start_cnt][0]   <= dmx_out;
        obs_ack[start_cnt]       <= hif.swap_ack;
        obs_start_cyc[start_cnt] <= cyc;
        if (busy !== 1'b1) obs_busy_bad[start_cnt] <= 1'b1;
      end
      cap_on    <= 1'b1;
      cap_idx   <= start_cnt;
      cap_n     <= 1;
      start_cnt <= start_cnt + 1;
    end else if (cap_on && cap_idx < NPKT) begin
      if (packet_done === 1'b1) begin
        obs_done[cap_idx] <= 1'b1;
        obs_len[cap_idx]  <= cap_n;
        cap_on            <= 1'b0;
      end else begin
        if (cap_n < WMAX) obs_wave[cap_idx][cap_n] <= dmx_out;
        if (busy !== 1'b1) obs_busy_bad[cap_idx] <= 1'b1;
        cap_n <= cap_n + 1;
      end
    end
  end

  // Reference side: channel banks, swap bookkeeping and per-packet expectations.
  int         errors = 0, checks = 0;
  logic [7:0] model_mem [2][CH];
  bit         model_active, model_pending;
  logic [7:0] exp_bytes [NPKT][CH];
  logic [7:0] exp_sc [NPKT];
  bit         exp_ack [NPKT];
  logic       exp_wave [WMAX];
  int         bad, raise_cyc;
  logic [7:0] r8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    hif.wr_en   = 1'b1;
    hif.wr_addr = AW'(a);
    hif.wr_data = d;
    model_mem[!model_active][a] = d;
    tick();
    hif.wr_en = 1'b0;
  endtask

  task automatic do_swap();
    hif.swap      = 1'b1;
    model_pending = 1'b1;
    tick();
    hif.swap = 1'b0;
  endtask

  // Called once all stimulus that can affect packet n has been applied.
  task automatic plan(input int n);
    exp_ack[n] = model_pending;
    if (model_pending) begin
      model_active  = !model_active;
      model_pending = 1'b0;
    end
    exp_sc[n] = start_code;
    for (int k = 0; k < CH; k++) exp_bytes[n][k] = model_mem[model_active][k];
  endtask

  task automatic wait_start(input int n);
    int i = 0;
    while (start_cnt <= n && i < 2000) begin tick(); i++; end
    chk($sformatf("start%0d", n), 32'(start_cnt > n), 1);
  endtask

  task automatic wait_done(input int n);
    int i = 0;
    while (!obs_done[n] && i < 1000) begin tick(); i++; end
    chk($sformatf("done%0d", n), 32'(obs_done[n]), 1);
  endtask

  task automatic go_to(input int n, input int off);
    while (cyc < obs_start_cyc[n] + off) tick();
  endtask

  task automatic check_packet(input int n);
    int idx, mism, base;
    logic [7:0] b, dec;
    idx = 0;
    for (int i = 0; i < BRK; i++) begin exp_wave[idx] = 1'b0; idx = idx + 1; end
    for (int i = 0; i < MABC; i++) begin exp_wave[idx] = 1'b1; idx = idx + 1; end
    for (int s = 0; s <= CH; s++) begin
      b = (s == 0) ? exp_sc[n] : exp_bytes[n][s-1];
      for (int i = 0; i < BITC; i++) begin exp_wave[idx] = 1'b0; idx = idx + 1; end
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < BITC; i++) begin exp_wave[idx] = b[k]; idx = idx + 1; end
      for (int i = 0; i < 2 * BITC; i++) begin exp_wave[idx] = 1'b1; idx = idx + 1; end
      if (s < CH)
        for (int i = 0; i < MTBS; i++) begin exp_wave[idx] = 1'b1; idx = idx + 1; end
    end
    for (int i = 0; i < MBB; i++) begin exp_wave[idx] = 1'b1; idx = idx + 1; end

    chk($sformatf("p%0d_len", n), obs_len[n], PKT_LEN);
    chk($sformatf("p%0d_ack", n), 32'(obs_ack[n]), 32'(exp_ack[n]));
    chk($sformatf("p%0d_busy", n), 32'(obs_busy_bad[n]), 0);
    mism = 0;
    for (int i = 0; i < PKT_LEN; i++) if (obs_wave[n][i] !== exp_wave[i]) mism++;
    chk($sformatf("p%0d_wave_mismatches", n), mism, 0);
    for (int s = 0; s <= CH; s++) begin
      base = BRK + MABC + s * (11 * BITC + MTBS);
      for (int k = 0; k < 8; k++) dec[k] = obs_wave[n][base + (1 + k) * BITC + BITC / 2];
      chk($sformatf("p%0d_slot%0d", n, s), dec, (s == 0) ? exp_sc[n] : exp_bytes[n][s-1]);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start_code = 8'h00;
    hif.wr_en = 1'b0; hif.wr_addr = '0; hif.wr_data = 8'h00; hif.swap = 1'b0;
    model_active = 1'b0; model_pending = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_dmx_out", dmx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_packet_start", packet_start, 0);
    chk("rst_packet_done", packet_done, 0);
    chk("rst_swap_ack", hif.swap_ack, 0);

    bad = 0;
    repeat (200) begin
      tick();
      if (dmx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_line", bad, 0);
    chk("idle_no_start", start_cnt, 0);
    chk("idle_no_done", done_total, 0);
    chk("idle_no_ack", ack_total, 0);

    // Packet 0: known bytes into the shadow, swap requested while idle.
    do_write(0, 8'h01); do_write(1, 8'h80); do_write(2, 8'hA5); do_write(3, 8'hFF);
    do_swap();
    start_code = 8'h00;
    plan(0);
    raise_cyc = cyc;
    enable = 1'b1;
    wait_start(0);
    chk("enable_to_start_latency", obs_start_cyc[0], raise_cyc + 1);

    go_to(0, 40);
    do_write(0, 8'($urandom));
    do_write(1, 8'($urandom));
    do_write(2, 8'h55);
    do_write(3, 8'($urandom));
    plan(1);
    wait_done(0);
    check_packet(0);

    // Packet 1: shadow writes must not show up; two swaps collapse into one.
    wait_start(1);
    chk("break_spacing", obs_start_cyc[1] - obs_start_cyc[0], PKT_LEN + 1);
    go_to(1, 40);
    do_swap();
    tick();
    do_swap();
    start_code = 8'hCC;
    plan(2);
    wait_done(1);
    check_packet(1);

    // Packet 2: start code changed during MAB must not leak into slot 0.
    wait_start(2);
    go_to(2, 22);
    start_code = 8'h17;
    for (int i = 0; i < 3; i++) do_write(int'($urandom_range(CH - 1, 0)), 8'($urandom));
    plan(3);
    wait_done(2);
    check_packet(2);

    // Packet 3: enable drops mid-DATA; packet still completes, no new break.
    wait_start(3);
    go_to(3, 60);
    enable = 1'b0;
    wait_done(3);
    check_packet(3);
    bad = 0;
    repeat (100) begin
      tick();
      if (dmx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("after_drop_line", bad, 0);
    chk("after_drop_no_break", start_cnt, 4);

    // Packet 4: swap to bank 1, then reset during a low data bit.
    do_swap();
    r8 = 8'($urandom);
    start_code = r8 & 8'hFE;
    plan(4);
    enable = 1'b1;
    wait_start(4);
    chk("p4_ack", 32'(obs_ack[4]), 32'(exp_ack[4]));
    go_to(4, BRK + MABC + BITC + 1);
    chk("pre_reset_line_low", dmx_out, 0);
    reset = 1'b1;
    tick();
    chk("reset_line_high", dmx_out, 1);
    chk("reset_busy_low", busy, 0);
    tick();
    model_active  = 1'b0;
    model_pending = 1'b0;
    plan(5);
    reset = 1'b0;

    // Packet 5: fresh packet after reset reads bank 0.
    wait_start(5);
    chk("p4_no_done", 32'(obs_done[4]), 0);
    wait_done(5);
    enable = 1'b0;
    check_packet(5);

    repeat (5) tick();
    chk("swap_ack_total", ack_total, 3);
    chk("swap_ack_stray", ack_stray, 0);
    chk("packet_done_total", done_total, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
